// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the host-link UART (uart_rx and uart_tx).
//   Contents:
//     FRAME_BITS    data bits per character (8N1 framing)
//     uart_state_t  receiver/transmitter FSM state encoding
//     baud_max()    clk cycles per bit for a given clock and line rate
//     baud_half()   clk cycles per half bit (mid-bit sampling offset)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int baud_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int baud_half(input int clk_freq, input int bps);
        return baud_max(clk_freq, bps) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Groups the receiver's serial input and its byte-output path.
//   Signals:
//     rs232_rx   serial line, idle high, asynchronous to clk
//     po_data    last correctly framed byte (bit0 = first data bit)
//     po_flag    one-clk pulse when po_data has been updated
//     frame_err  one-clk pulse when the stop bit was sampled low
//   Modports:
//     master     the receiver (consumes rs232_rx, drives the byte outputs)
//     slave      the user side (drives rs232_rx, consumes the byte outputs)
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic                  rs232_rx;
    logic [FRAME_BITS-1:0] po_data;
    logic                  po_flag;
    logic                  frame_err;

    modport master (
        input  rs232_rx,
        output po_data,
        output po_flag,
        output frame_err
    );

    modport slave (
        output rs232_rx,
        input  po_data,
        input  po_flag,
        input  frame_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial line plus a third flop
//   used to detect falling edges of the synchronized signal.
//   Ports:
//     clk    system clock
//     rstn   asynchronous active-low reset; all flops reset to 1 (line idle)
//     din    raw serial input
//     dout   synchronized line level
//     fall   high for one cycle when dout goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    // Resetting to 1 keeps a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= din;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign dout = rx_s2;
    assign fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, LSB first, idle-high line. Each correctly framed byte
//   is presented on po_data with a one-clk po_flag pulse; a low stop bit
//   raises a one-clk frame_err pulse and the byte is dropped.
//   Parameters:
//     UART_BPS   line rate in bit/s
//     CLK_FREQ   clk frequency in Hz
//   Ports:
//     clk        system clock
//     rstn       asynchronous active-low reset
//     bus        uart_rx_if.master (rs232_rx in; po_data/po_flag/frame_err out)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic      clk,
    input  logic      rstn,
    uart_rx_if.master bus
);

    localparam int BAUD_MAX = baud_max(CLK_FREQ, UART_BPS);
    localparam int HALF     = baud_half(CLK_FREQ, UART_BPS);
    localparam int CNT_W    = $clog2(BAUD_MAX);
    localparam int BIT_W    = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_MAX - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_state_t           state,     state_nxt;
    logic [CNT_W-1:0]      baud_cnt,  baud_nxt;
    logic [BIT_W-1:0]      bit_cnt,   bit_nxt;
    logic [FRAME_BITS-1:0] shift_reg, shift_nxt;
    logic [FRAME_BITS-1:0] data_q,    data_nxt;
    logic                  flag_q,    flag_nxt;
    logic                  err_q,     err_nxt;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (bus.rs232_rx),
        .dout (rx_s),
        .fall (rx_fall)
    );

    // All receiver state is registered here; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            data_q    <= data_nxt;
            flag_q    <= flag_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state logic. Sampling happens at HALF into the start bit and then
    // every BAUD_MAX, i.e. at the middle of each bit. IDLE only leaves on a
    // falling edge, so a line held low after a framing error never re-triggers.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        data_nxt  = data_q;
        flag_nxt  = 1'b0;
        err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                baud_nxt = '0;
                if (rx_fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_nxt = '0;
                    bit_nxt  = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {rx_s, shift_reg[FRAME_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt = shift_reg;
                        flag_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.po_data   = data_q;
    assign bus.po_flag   = flag_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Runs at a scaled baud (32 clk per bit)
//   so that every scenario, including multi-frame breaks, stays short.
//   A line-level monitor records every po_flag/frame_err pulse; each test
//   task compares what it observed with what the framing rules predict for
//   the bytes it sent.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ = 3_200_000;
    localparam int UART_BPS = 100_000;
    localparam int BIT      = CLK_FREQ / UART_BPS;
    localparam int HALF     = BIT / 2;
    localparam int LATENCY  = HALF + 9 * BIT;
    localparam int SLACK    = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if rx_if ();

    uart_rx #(
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (rx_if.master)
    );

    int checks = 0;
    int errors = 0;

    int cycle        = 0;
    int flag_cnt     = 0;
    int err_cnt      = 0;
    int both_cnt     = 0;
    int unstable_cnt = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] got_q[$];
    int         flag_cycle_q[$];

    // Reference model state: the last byte that should be on po_data.
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cycle++;

    // Line monitor: logs every output pulse and watches the output invariants.
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_if.po_flag) begin
                flag_cnt++;
                got_q.push_back(rx_if.po_data);
                flag_cycle_q.push_back(cycle);
            end
            if (rx_if.frame_err) err_cnt++;
            if (rx_if.po_flag && rx_if.frame_err) both_cnt++;
            if (!rx_if.po_flag && rx_if.po_data !== prev_data) unstable_cnt++;
        end
        prev_data = rx_if.po_data;
    end

    // Drives the first nbits of a 10-bit frame image, one bit per BIT clocks.
    task automatic applyStimulus(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_if.rs232_rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, output int start_cycle);
        start_cycle = cycle;
        applyStimulus({stop_bit, d, 1'b0}, 10);
    endtask

    task automatic idle(input int n);
        rx_if.rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_if.rs232_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_if.po_data !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_po_data: got %h want 00", rx_if.po_data);
        end
        checks++;
        if (rx_if.po_flag !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_po_flag: got %b want 0", rx_if.po_flag);
        end
        checks++;
        if (rx_if.frame_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_frame_err: got %b want 0", rx_if.frame_err);
        end
        rstn = 1'b1;
        idle(BIT);
        checks++;
        if (flag_cnt + err_cnt !== 0) begin
            errors++; $display("[TB] FAIL reset_quiet: got %0d pulses want 0", flag_cnt + err_cnt);
        end
        last_good = 8'h00;
    endtask

    task automatic test_single();
        int f0 = flag_cnt;
        int e0 = err_cnt;
        int sc;
        int lat;
        send_byte(8'h55, 1'b1, sc);
        idle(BIT);
        last_good = 8'h55;
        checks++;
        if (flag_cnt - f0 !== 1) begin
            errors++; $display("[TB] FAIL single_flag_count: got %0d want 1", flag_cnt - f0);
        end
        checks++;
        if (got_q[got_q.size()-1] !== 8'h55) begin
            errors++; $display("[TB] FAIL single_data: got %h want 55", got_q[got_q.size()-1]);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++; $display("[TB] FAIL single_frame_err: got %0d want 0", err_cnt - e0);
        end
        lat = flag_cycle_q[flag_cycle_q.size()-1] - sc;
        checks++;
        if (lat < LATENCY - SLACK || lat > LATENCY + SLACK) begin
            errors++; $display("[TB] FAIL single_latency: got %0d want %0d+/-%0d", lat, LATENCY, SLACK);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = flag_cnt;
        int sc;
        int gap;
        send_byte(8'hA3, 1'b1, sc);
        send_byte(8'h0F, 1'b1, sc);
        idle(BIT);
        last_good = 8'h0F;
        checks++;
        if (flag_cnt - f0 !== 2) begin
            errors++; $display("[TB] FAIL b2b_flag_count: got %0d want 2", flag_cnt - f0);
        end
        checks++;
        if (got_q[got_q.size()-2] !== 8'hA3) begin
            errors++; $display("[TB] FAIL b2b_first: got %h want a3", got_q[got_q.size()-2]);
        end
        checks++;
        if (got_q[got_q.size()-1] !== 8'h0F) begin
            errors++; $display("[TB] FAIL b2b_second: got %h want 0f", got_q[got_q.size()-1]);
        end
        gap = flag_cycle_q[flag_cycle_q.size()-1] - flag_cycle_q[flag_cycle_q.size()-2];
        checks++;
        if (gap < 10 * BIT - SLACK || gap > 10 * BIT + SLACK) begin
            errors++; $display("[TB] FAIL b2b_spacing: got %0d want %0d+/-%0d", gap, 10 * BIT, SLACK);
        end
    endtask

    task automatic test_glitch();
        int f0 = flag_cnt;
        int e0 = err_cnt;
        int sc;
        rx_if.rs232_rx = 1'b0;
        repeat (HALF - 10) @(negedge clk);
        idle(12 * BIT);
        checks++;
        if (flag_cnt - f0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_ignored: got flag %0d err %0d want 0 0", flag_cnt - f0, err_cnt - e0);
        end
        send_byte(8'h3C, 1'b1, sc);
        idle(BIT);
        last_good = 8'h3C;
        checks++;
        if (flag_cnt - f0 !== 1 || got_q[got_q.size()-1] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL glitch_next_frame: got %0d flags data %h want 1 flag data 3c",
                     flag_cnt - f0, got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_frame_err();
        int f0 = flag_cnt;
        int e0 = err_cnt;
        int sc;
        send_byte(8'h81, 1'b0, sc);
        idle(2 * BIT);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++; $display("[TB] FAIL ferr_pulse: got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (flag_cnt - f0 !== 0) begin
            errors++; $display("[TB] FAIL ferr_no_flag: got %0d want 0", flag_cnt - f0);
        end
        checks++;
        if (rx_if.po_data !== last_good) begin
            errors++; $display("[TB] FAIL ferr_data_held: got %h want %h", rx_if.po_data, last_good);
        end
    endtask

    task automatic test_break();
        int f0 = flag_cnt;
        int e0 = err_cnt;
        int sc;
        rx_if.rs232_rx = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        idle(2 * BIT);
        checks++;
        if (err_cnt - e0 !== 1 || flag_cnt - f0 !== 0) begin
            errors++;
            $display("[TB] FAIL break_single_err: got err %0d flag %0d want 1 0", err_cnt - e0, flag_cnt - f0);
        end
        send_byte(8'h7E, 1'b1, sc);
        idle(BIT);
        last_good = 8'h7E;
        checks++;
        if (flag_cnt - f0 !== 1 || rx_if.po_data !== 8'h7E) begin
            errors++;
            $display("[TB] FAIL break_recover: got %0d flags data %h want 1 flag data 7e",
                     flag_cnt - f0, rx_if.po_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame = {1'b1, 8'hB5, 1'b0};
        int f0;
        int e0;
        int sc;
        applyStimulus(frame, 5);
        rx_if.rs232_rx = frame[5];
        repeat (HALF) @(negedge clk);
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_if.po_data !== 8'h00 || rx_if.po_flag !== 1'b0 || rx_if.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got data %h flag %b err %b want 00 0 0",
                     rx_if.po_data, rx_if.po_flag, rx_if.frame_err);
        end
        rx_if.rs232_rx = 1'b1;
        rstn = 1'b1;
        last_good = 8'h00;
        f0 = flag_cnt;
        e0 = err_cnt;
        idle(12 * BIT);
        checks++;
        if (flag_cnt - f0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_aborted: got flag %0d err %0d want 0 0", flag_cnt - f0, err_cnt - e0);
        end
        send_byte(8'hC6, 1'b1, sc);
        idle(BIT);
        last_good = 8'hC6;
        checks++;
        if (flag_cnt - f0 !== 1 || rx_if.po_data !== 8'hC6) begin
            errors++;
            $display("[TB] FAIL midreset_next: got %0d flags data %h want 1 flag data c6",
                     flag_cnt - f0, rx_if.po_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int base = got_q.size();
        int f0 = flag_cnt;
        int e0 = err_cnt;
        int exp_err = 0;
        int sc;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d = 8'($urandom);
            logic good = ($urandom_range(0, 3) != 0);
            send_byte(d, good, sc);
            if (good) begin
                exp_q.push_back(d);
                last_good = d;
            end else begin
                exp_err++;
                idle(BIT);
            end
        end
        idle(BIT);
        checks++;
        if (flag_cnt - f0 !== exp_q.size()) begin
            errors++; $display("[TB] FAIL random_flag_count: got %0d want %0d", flag_cnt - f0, exp_q.size());
        end
        checks++;
        if (err_cnt - e0 !== exp_err) begin
            errors++; $display("[TB] FAIL random_err_count: got %0d want %0d", err_cnt - e0, exp_err);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL random_byte%0d: got %h want %h", i,
                         (base + i < got_q.size()) ? got_q[base + i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (rx_if.po_data !== last_good) begin
            errors++; $display("[TB] FAIL random_last_data: got %h want %h", rx_if.po_data, last_good);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("[TB] FAIL flag_and_err_together: got %0d cycles want 0", both_cnt);
        end
        checks++;
        if (unstable_cnt !== 0) begin
            errors++; $display("[TB] FAIL data_change_without_flag: got %0d cycles want 0", unstable_cnt);
        end
    endtask

    initial begin
        rx_if.rs232_rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
